// File: rtl/crc16_frame_checker_if.sv
// Byte-stream bundle between the link deserializer (master) and the CRC-16 frame checker (slave).
// Carries the received byte stream in, the stripped payload out, and the frame status/counters.
interface crc16_frame_checker_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_sof;
  logic             in_eof;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_last;
  logic             crc_ok;
  logic             crc_err;
  logic             len_err;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;

  modport master (
    output in_valid, in_data, in_sof, in_eof,
    input  out_valid, out_data, out_last, crc_ok, crc_err, len_err, good_cnt, bad_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sof, in_eof,
    output out_valid, out_data, out_last, crc_ok, crc_err, len_err, good_cnt, bad_cnt
  );
endinterface

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 (poly 0x8005, init 0, MSB first) frame checker: strips the two trailing
// CRC bytes, forwards payload through a 2-byte hold buffer, flags frames and counts good/bad.
module crc16_frame_checker #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  crc16_frame_checker_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  function automatic logic [15:0] crc_next(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h8005;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [7:0]       slot_a_q, slot_a_d;
  logic [7:0]       slot_b_q, slot_b_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             crc_ok_q, crc_ok_d;
  logic             crc_err_q, crc_err_d;
  logic             len_err_q, len_err_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [15:0]      crc_upd_s;
  logic [15:0]      crc_first_s;

  assign crc_upd_s   = crc_next(crc_q, bus.in_data);
  assign crc_first_s = crc_next(16'h0000, bus.in_data);

  // Next-state, hold buffer and output pulse logic
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    slot_a_d    = slot_a_q;
    slot_b_d    = slot_b_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_last_d  = 1'b0;
    crc_ok_d    = 1'b0;
    crc_err_d   = 1'b0;
    len_err_d   = 1'b0;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;

    if (crc_ok_q && (good_cnt_q != {CNT_W{1'b1}})) begin
      good_cnt_d = good_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      good_cnt_d = good_cnt_q;
    end
    if (crc_err_q && (bad_cnt_q != {CNT_W{1'b1}})) begin
      bad_cnt_d = bad_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bad_cnt_d = bad_cnt_q;
    end

    if (bus.in_valid) begin
      if (bus.in_sof) begin
        // A sof while still receiving aborts the old frame; the new one starts this cycle.
        if (state_q == RECV) begin
          crc_err_d = 1'b1;
        end else begin
          crc_err_d = 1'b0;
        end
        if (bus.in_eof) begin
          crc_err_d = 1'b1;
          len_err_d = 1'b1;
          state_d   = IDLE;
          crc_d     = 16'h0000;
          cnt_d     = 2'd0;
        end else begin
          state_d  = RECV;
          crc_d    = crc_first_s;
          cnt_d    = 2'd1;
          slot_a_d = bus.in_data;
        end
      end else if (state_q == RECV) begin
        if (bus.in_eof) begin
          state_d = IDLE;
          crc_d   = 16'h0000;
          cnt_d   = 2'd0;
          if (cnt_q < 2'd2) begin
            crc_err_d = 1'b1;
            len_err_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = slot_a_q;
            out_last_d  = 1'b1;
            if (crc_upd_s == 16'h0000) begin
              crc_ok_d = 1'b1;
            end else begin
              crc_err_d = 1'b1;
            end
          end
        end else begin
          crc_d = crc_upd_s;
          if (cnt_q != 2'd3) begin
            cnt_d = cnt_q + 2'd1;
          end else begin
            cnt_d = cnt_q;
          end
          // Two bytes held means the oldest is now known to be payload, not CRC.
          if (cnt_q >= 2'd2) begin
            out_valid_d = 1'b1;
            out_data_d  = slot_a_q;
            slot_a_d    = slot_b_q;
            slot_b_d    = bus.in_data;
          end else begin
            slot_b_d = bus.in_data;
          end
        end
      end else begin
        state_d = IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crc_q       <= 16'h0000;
      cnt_q       <= 2'd0;
      slot_a_q    <= 8'h00;
      slot_b_q    <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      good_cnt_q  <= {CNT_W{1'b0}};
      bad_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      slot_a_q    <= slot_a_d;
      slot_b_q    <= slot_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.crc_ok    = crc_ok_q;
  assign bus.crc_err   = crc_err_q;
  assign bus.len_err   = len_err_q;
  assign bus.good_cnt  = good_cnt_q;
  assign bus.bad_cnt   = bad_cnt_q;

endmodule

// File: doc/crc16_frame_checker.md
# crc16_frame_checker

Receive-side companion to the parallel CRC-16 generator: consumes the byte stream that generator emits (payload bytes followed by two CRC bytes, MSB first) and recomputes CRC-16 (poly 0x8005, init 0x0000, no reflection, no final XOR) one byte per clock. It strips the two trailing CRC bytes and forwards only the payload downstream. It flags each frame good or bad, and keeps saturating good/bad frame counters. It sits between the link deserializer and the payload consumer.

## Interface
- CNT_W, 16, width of the good/bad frame counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data/in_sof/in_eof qualified this cycle
- in_data  in  8  received byte
- in_sof  in  1  first byte of frame (qualified by in_valid)
- in_eof  in  1  last byte of frame, i.e. CRC low byte (qualified by in_valid)
- out_valid  out  1  payload byte on out_data
- out_data  out  8  payload byte
- out_last  out  1  with out_valid: last payload byte of frame
- crc_ok  out  1  one-cycle pulse: frame ended with zero residue
- crc_err  out  1  one-cycle pulse: frame bad (non-zero residue, too short, or aborted)
- len_err  out  1  one-cycle pulse: frame shorter than 3 bytes (accompanies crc_err)
- good_cnt  out  CNT_W  count of crc_ok pulses, saturating
- bad_cnt  out  CNT_W  count of crc_err pulses, saturating

## Operation
- States: IDLE and RECV. Reset enters IDLE.
- IDLE: bytes without in_sof are discarded, including a lone in_eof. in_valid && in_sof loads crc = next(0x0000, in_data), sets byte count = 1, places the byte in hold slot A, and goes to RECV.
- in_sof && in_eof on the same byte: 1-byte frame. Raise crc_err and len_err, stay in IDLE.
- RECV, each in_valid byte: crc <= next(crc, in_data), bit 7 processed first. The byte count increments and saturates at 3.
- The hold buffer is 2 bytes deep. When a byte arrives with both slots full, the oldest byte goes to out_data with out_valid, and the new byte enters the buffer.
- RECV with in_eof:
  - If count including this byte is < 3: crc_err and len_err, no output.
  - Otherwise the oldest held byte is emitted with out_last = 1, and the remaining held byte plus the eof byte (the CRC bytes) are dropped.
  - crc_ok if next(crc, in_data) == 0, else crc_err.
  - Return to IDLE.
- RECV with in_sof (no eof on the previous frame): the old frame is aborted. Pulse crc_err with no out_last; held bytes are dropped. The new frame starts exactly as from IDLE, in the same cycle.
- in_valid low: all state holds, no outputs.
- Counters: good_cnt increments on each crc_ok pulse, bad_cnt on each crc_err pulse. Both saturate at 2^CNT_W−1 and never wrap.
- Async reset mid-frame: everything clears immediately, no pulses are generated, and the partial frame is lost.

## Timing
- Reset values: out_valid, out_data, out_last, crc_ok, crc_err, len_err, good_cnt and bad_cnt are all 0. State is IDLE, crc is 0x0000, the hold buffer is empty.
- All outputs are registered.
- Payload byte k appears on out_data one cycle after the accepted byte k+2.
- crc_ok, crc_err, len_err and out_last assert one cycle after the accepted eof byte, all in the same cycle.
- The abort crc_err pulse occurs one cycle after the interrupting in_sof byte.
- Counters update one cycle after their pulse.
- Full throughput: one byte per clock with back-to-back frames (sof on the cycle right after eof) and no bubbles. out_valid never exceeds one byte per cycle.
- There is no backpressure; the downstream consumer must accept every out_valid.

## Test plan
- Frame 0x31..0x39 ("123456789") + 0xFE 0xE8, contiguous -> out_data 0x31..0x39, out_last with 0x39, crc_ok = 1, good_cnt = 1.
- Frame 0x01 0x80 0x05, with in_valid low for 3 cycles between bytes -> single output 0x01 with out_last, crc_ok; no output during gaps.
- "123456789" + 0xFE 0xE9 -> all 9 payload bytes forwarded, crc_err = 1, bad_cnt = 1, good_cnt unchanged.
- Short frames: sof+eof byte 0xAA; then 2-byte frame 0x80 0x05 -> each gives crc_err + len_err, no out_valid, bad_cnt = 2.
- Abort and back-to-back: 0x11 0x22 0x33, then sof on 0x01 0x80 0x05(eof), immediately followed by "123456789"+0xFE 0xE8 -> 0x11 emitted without out_last, crc_err once, then crc_ok twice, good_cnt = 2.
- rst_n pulsed low mid-frame after 5 bytes; then a valid frame is sent -> no pulses from the partial frame, all outputs 0 during reset, next frame crc_ok. Force bad_cnt to saturate with CNT_W = 2 -> holds at 3.
